echo_driver: RTL and testbench

- Initiator end of the Echo protocol. Acts as client of EchoRequest (issues say/say2) and server of EchoIndication (accepts heard/heard2).
- Accepts host commands, issues one request at a time to an Echo responder, and checks the echoed response against the sent payload.
- Keeps pass/fail/timeout counters and the last round-trip latency.
- Sits between a host or test sequencer and an Echo instance.

---
 rtl/echo_pkg.sv | 26 ++
 rtl/echo_driver_sat_counter.sv | 30 +++
 rtl/echo_driver.sv | 170 +++++++++++++++++
 tb/tb_echo_driver.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared definitions for the Echo initiator: payload widths, request kinds,
// transaction result codes and FSM state encodings.
package echo_pkg;

  localparam int V_W  = 32;
  localparam int AB_W = 16;

  // Request kind latched from the host command.
  localparam logic KIND_SAY  = 1'b0;
  localparam logic KIND_SAY2 = 1'b1;

  // Outcome of a finished transaction, reported alongside the done pulse.
  typedef enum logic [1:0] {
    RES_PASS = 2'd0,
    RES_FAIL = 2'd1,
    RES_TMO  = 2'd2
  } result_e;

  // FSM encoding kept as plain constants so older tools and scripts can
  // still match on raw state values.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

endpackage

// File: rtl/echo_driver_sat_counter.sv
// Saturating up-counter with clear and parallel load. Holds at all-ones
// instead of wrapping, so statistics never roll back to small values.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  // Clear beats load beats increment; increment stops at all-ones.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/echo_driver.sv
// Initiator end of the Echo protocol. Takes one host command at a time,
// issues it as say/say2, waits for the heard/heard2 echo, and reports
// pass/fail/timeout with saturating statistics and round-trip latency.
module echo_driver
  import echo_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16,
  parameter int LAT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  // host command
  input  logic             cmd__ENA,
  output logic             cmd__RDY,
  input  logic             cmd_kind,
  input  logic [V_W-1:0]   cmd_v,
  input  logic [AB_W-1:0]  cmd_a,
  input  logic [AB_W-1:0]  cmd_b,
  // EchoRequest (client side)
  output logic             say__ENA,
  output logic [V_W-1:0]   say_v,
  input  logic             say__RDY,
  output logic             say2__ENA,
  output logic [AB_W-1:0]  say2_a,
  output logic [AB_W-1:0]  say2_b,
  input  logic             say2__RDY,
  // EchoIndication (server side)
  input  logic             heard__ENA,
  input  logic [V_W-1:0]   heard_v,
  output logic             heard__RDY,
  input  logic             heard2__ENA,
  input  logic [AB_W-1:0]  heard2_a,
  input  logic [AB_W-1:0]  heard2_b,
  output logic             heard2__RDY,
  // status
  output logic             done,
  output logic [1:0]       result,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] tmo_cnt,
  output logic [LAT_W-1:0] last_lat
);

  state_t            state;
  state_t            state_nxt;
  logic              exp_kind;
  logic [V_W-1:0]    exp_v;
  logic [AB_W-1:0]   exp_a;
  logic [AB_W-1:0]   exp_b;
  logic [LAT_W-1:0]  lat_ctr;
  logic [LAT_W-1:0]  lat_next;
  result_e           result_q;

  logic cmd_fire;
  logic issue_fire;
  logic heard_fire;
  logic heard2_fire;
  logic resp_fire;
  logic resp_ok;
  logic tmo_hit;

  // Handshake outputs depend only on state, the latched command and the
  // responder's RDY, so an output ENA can never rise without its RDY.
  always_comb begin
    cmd__RDY    = (state == ST_IDLE);
    say__ENA    = (state == ST_ISSUE) && (exp_kind == KIND_SAY)  && say__RDY;
    say2__ENA   = (state == ST_ISSUE) && (exp_kind == KIND_SAY2) && say2__RDY;
    say_v       = exp_v;
    say2_a      = exp_a;
    say2_b      = exp_b;
    heard__RDY  = (state == ST_WAIT);
    heard2__RDY = (state == ST_WAIT);
  end

  // Fire qualifiers, response checking and timeout detection.
  always_comb begin
    cmd_fire    = cmd__ENA && cmd__RDY;
    issue_fire  = say__ENA || say2__ENA;
    heard_fire  = heard__ENA && heard__RDY;
    heard2_fire = heard2__ENA && heard2__RDY;
    resp_fire   = heard_fire || heard2_fire;
    // Exactly one response of the expected type with a bit-exact payload;
    // a double response is a protocol error even if both payloads match.
    resp_ok     = (heard_fire && !heard2_fire && (exp_kind == KIND_SAY) &&
                   (heard_v == exp_v)) ||
                  (heard2_fire && !heard_fire && (exp_kind == KIND_SAY2) &&
                   (heard2_a == exp_a) && (heard2_b == exp_b));
    // A response on the last allowed cycle still wins over the timeout.
    tmo_hit     = (state == ST_WAIT) && !resp_fire &&
                  (lat_ctr == LAT_W'(TIMEOUT - 1));
    lat_next    = (lat_ctr == '1) ? lat_ctr : lat_ctr + LAT_W'(1);
  end

  // Next-state selection for the single-transaction IDLE/ISSUE/WAIT loop.
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no
    // latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_fire)             state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue_fire)           state_nxt = ST_WAIT;
      ST_WAIT:  if (resp_fire || tmo_hit) state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Latch the command so the payload stays stable through ISSUE and WAIT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      exp_kind <= KIND_SAY;
      exp_v    <= '0;
      exp_a    <= '0;
      exp_b    <= '0;
    end else if (cmd_fire) begin
      exp_kind <= cmd_kind;
      exp_v    <= cmd_v;
      exp_a    <= cmd_a;
      exp_b    <= cmd_b;
    end
  end

  // One-cycle done pulse with the outcome of the transaction just closed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done     <= 1'b0;
      result_q <= RES_PASS;
    end else begin
      done <= resp_fire || tmo_hit;
      if (resp_fire)    result_q <= resp_ok ? RES_PASS : RES_FAIL;
      else if (tmo_hit) result_q <= RES_TMO;
    end
  end

  assign result = result_q;

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk(CLK), .rst(RST), .clr(1'b0), .inc(resp_fire && resp_ok),
    .load(1'b0), .load_val('0), .count(pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk(CLK), .rst(RST), .clr(1'b0), .inc(resp_fire && !resp_ok),
    .load(1'b0), .load_val('0), .count(fail_cnt)
  );

  sat_counter #(.W(CNT_W)) u_tmo_cnt (
    .clk(CLK), .rst(RST), .clr(1'b0), .inc(tmo_hit),
    .load(1'b0), .load_val('0), .count(tmo_cnt)
  );

  // Cycles spent in WAIT; restarted on the request fire.
  sat_counter #(.W(LAT_W)) u_lat_ctr (
    .clk(CLK), .rst(RST), .clr(issue_fire), .inc(state == ST_WAIT),
    .load(1'b0), .load_val('0), .count(lat_ctr)
  );

  // Latency includes the accept cycle itself; timeouts leave it untouched.
  sat_counter #(.W(LAT_W)) u_last_lat (
    .clk(CLK), .rst(RST), .clr(1'b0), .inc(1'b0),
    .load(resp_fire), .load_val(lat_next), .count(last_lat)
  );

endmodule

// File: tb/tb_echo_driver.sv
// Self-checking bench for echo_driver. The bench plays host and responder;
// expected outcomes are queued when a command is issued and compared when
// the done pulse appears.
module tb_echo_driver;

  localparam int TMO = 8;

  localparam int M_OK      = 0;  // correct echo
  localparam int M_BADPAY  = 1;  // right type, wrong payload
  localparam int M_BADTYPE = 2;  // other response type
  localparam int M_BOTH    = 3;  // heard and heard2 together
  localparam int M_NONE    = 4;  // never respond

  typedef struct {
    logic [1:0]  res;
    logic [15:0] lat;
    int          cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_ena, cmd_rdy, cmd_kind;
  logic [31:0] cmd_v;
  logic [15:0] cmd_a, cmd_b;
  logic        say_ena, say_rdy, say2_ena, say2_rdy;
  logic [31:0] say_v;
  logic [15:0] say2_a, say2_b;
  logic        heard_ena, heard_rdy, heard2_ena, heard2_rdy;
  logic [31:0] heard_v;
  logic [15:0] heard2_a, heard2_b;
  logic        done;
  logic [1:0]  result;
  logic [15:0] pass_cnt, fail_cnt, tmo_cnt, last_lat;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  logic [15:0] pass_m, fail_m, tmo_m, lat_m;

  always #5 CLK = ~CLK;

  echo_driver #(.TIMEOUT(TMO), .CNT_W(16), .LAT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .cmd__ENA(cmd_ena), .cmd__RDY(cmd_rdy), .cmd_kind(cmd_kind),
    .cmd_v(cmd_v), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .say__ENA(say_ena), .say_v(say_v), .say__RDY(say_rdy),
    .say2__ENA(say2_ena), .say2_a(say2_a), .say2_b(say2_b), .say2__RDY(say2_rdy),
    .heard__ENA(heard_ena), .heard_v(heard_v), .heard__RDY(heard_rdy),
    .heard2__ENA(heard2_ena), .heard2_a(heard2_a), .heard2_b(heard2_b),
    .heard2__RDY(heard2_rdy),
    .done(done), .result(result),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt),
    .last_lat(last_lat)
  );

  // Hard stop in case the design wedges somewhere the tasks do not bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_idle_status(input string tag);
    total++;
    if ({cmd_rdy, done, heard_rdy, heard2_rdy, say_ena, say2_ena} !== 6'b100000) begin
      bad++;
      $display("FAIL %s_handshake: got rdy/done/hrdy/h2rdy/say/say2=%b required 100000",
               tag, {cmd_rdy, done, heard_rdy, heard2_rdy, say_ena, say2_ena});
    end
    total++;
    if ({pass_cnt, fail_cnt, tmo_cnt, last_lat} !== {pass_m, fail_m, tmo_m, lat_m}) begin
      bad++;
      $display("FAIL %s_stats: got pass=%0d fail=%0d tmo=%0d lat=%0d required %0d %0d %0d %0d",
               tag, pass_cnt, fail_cnt, tmo_cnt, last_lat, pass_m, fail_m, tmo_m, lat_m);
    end
  endtask

  // Drive the response for the current mode during a WAIT cycle.
  task automatic drive_resp(input logic k, input logic [31:0] v,
                            input logic [15:0] a, input logic [15:0] b, input int mode);
    case (mode)
      M_OK: begin
        if (k == 1'b0) begin heard_ena = 1'b1; heard_v = v; end
        else begin heard2_ena = 1'b1; heard2_a = a; heard2_b = b; end
      end
      M_BADPAY: begin
        if (k == 1'b0) begin heard_ena = 1'b1; heard_v = v + 32'd1; end
        else begin heard2_ena = 1'b1; heard2_a = a; heard2_b = b ^ 16'h0001; end
      end
      M_BADTYPE: begin
        if (k == 1'b0) begin heard2_ena = 1'b1; heard2_a = v[31:16]; heard2_b = v[15:0]; end
        else begin heard_ena = 1'b1; heard_v = {a, b}; end
      end
      default: begin
        heard_ena = 1'b1; heard_v = v;
        heard2_ena = 1'b1; heard2_a = a; heard2_b = b;
      end
    endcase
  endtask

  // One full transaction: command, optional backpressure, response after
  // `delay` WAIT cycles, then outcome checks against the scoreboard.
  task automatic run_txn(input logic k, input logic [31:0] v, input logic [15:0] a,
                         input logic [15:0] b, input int mode, input int delay,
                         input int hold, input string tag);
    exp_t e;
    int   cyc;
    bit   seen;
    e.res = (mode == M_OK) ? 2'd0 : (mode == M_NONE) ? 2'd2 : 2'd1;
    e.cyc = (mode == M_NONE) ? TMO + 1 : delay + 1;
    e.lat = (mode == M_NONE) ? lat_m : 16'(delay);
    sb.push_back(e);

    @(negedge CLK);
    total++;
    if (cmd_rdy !== 1'b1) begin
      bad++; $display("FAIL %s_cmd_rdy: got %b required 1", tag, cmd_rdy);
    end
    cmd_ena = 1'b1; cmd_kind = k; cmd_v = v; cmd_a = a; cmd_b = b;
    say_rdy = (hold == 0); say2_rdy = (hold == 0);
    @(negedge CLK);
    cmd_ena = 1'b0;
    for (int i = 0; i < hold; i++) begin
      total++;
      if ({say_ena, say2_ena, done} !== 3'b000) begin
        bad++; $display("FAIL %s_backpressure: got say/say2/done=%b required 000",
                        tag, {say_ena, say2_ena, done});
      end
      @(negedge CLK);
    end
    say_rdy = 1'b1; say2_rdy = 1'b1;
    #1;
    total++;
    if (k == 1'b0) begin
      if ({say_ena, say2_ena, say_v} !== {2'b10, v}) begin
        bad++; $display("FAIL %s_say_issue: got ena=%b v=%h required 10 v=%h",
                        tag, {say_ena, say2_ena}, say_v, v);
      end
    end else begin
      if ({say_ena, say2_ena, say2_a, say2_b} !== {2'b01, a, b}) begin
        bad++; $display("FAIL %s_say2_issue: got ena=%b a=%h b=%h required 01 a=%h b=%h",
                        tag, {say_ena, say2_ena}, say2_a, say2_b, a, b);
      end
    end

    seen = 1'b0; cyc = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge CLK);
      heard_ena = 1'b0; heard2_ena = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1; cyc = c;
      end else if (c == delay && mode != M_NONE) begin
        total++;
        if ({heard_rdy, heard2_rdy} !== 2'b11) begin
          bad++; $display("FAIL %s_wait_rdy: got %b required 11", tag, {heard_rdy, heard2_rdy});
        end
        drive_resp(k, v, a, b, mode);
      end
    end
    heard_ena = 1'b0; heard2_ena = 1'b0;

    e = sb.pop_front();
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s_done_seen: got no done in 40 cycles required done", tag);
    end else begin
      if (e.res == 2'd0) pass_m++;
      else if (e.res == 2'd1) fail_m++;
      else tmo_m++;
      lat_m = e.lat;
      total++;
      if (cyc != e.cyc) begin
        bad++; $display("FAIL %s_done_time: got cycle %0d required %0d", tag, cyc, e.cyc);
      end
      total++;
      if (result !== e.res) begin
        bad++; $display("FAIL %s_result: got %0d required %0d", tag, result, e.res);
      end
      total++;
      if ({pass_cnt, fail_cnt, tmo_cnt, last_lat} !== {pass_m, fail_m, tmo_m, lat_m}) begin
        bad++;
        $display("FAIL %s_stats: got pass=%0d fail=%0d tmo=%0d lat=%0d required %0d %0d %0d %0d",
                 tag, pass_cnt, fail_cnt, tmo_cnt, last_lat, pass_m, fail_m, tmo_m, lat_m);
      end
      total++;
      if ({cmd_rdy, heard_rdy} !== 2'b10) begin
        bad++; $display("FAIL %s_back_idle: got cmd_rdy/heard_rdy=%b required 10",
                        tag, {cmd_rdy, heard_rdy});
      end
      @(negedge CLK);
      total++;
      if (done !== 1'b0) begin
        bad++; $display("FAIL %s_done_pulse: got %b required 0", tag, done);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; cmd_ena = 1'b0; cmd_kind = 1'b0; cmd_v = '0; cmd_a = '0; cmd_b = '0;
    say_rdy = 1'b1; say2_rdy = 1'b1;
    heard_ena = 1'b0; heard_v = '0; heard2_ena = 1'b0; heard2_a = '0; heard2_b = '0;
    pass_m = '0; fail_m = '0; tmo_m = '0; lat_m = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check_idle_status("reset");
    total++;
    if (result !== 2'd0) begin
      bad++; $display("FAIL reset_result: got %0d required 0", result);
    end
  endtask

  task automatic test_say();
    run_txn(1'b0, 32'h1234_5678, 16'h0, 16'h0, M_OK, 2, 0, "say");
  endtask

  task automatic test_say2();
    run_txn(1'b1, 32'h0, 16'hBEEF, 16'h0001, M_OK, 2, 0, "say2");
  endtask

  task automatic test_wrong();
    run_txn(1'b0, 32'd5, 16'h0, 16'h0, M_BADPAY, 1, 0, "wrong_payload");
    run_txn(1'b0, 32'd5, 16'h0, 16'h0, M_BADTYPE, 3, 0, "wrong_type");
    run_txn(1'b1, 32'h0, 16'h1111, 16'h2222, M_BADPAY, 2, 0, "wrong_payload2");
    run_txn(1'b1, 32'h0, 16'h3333, 16'h4444, M_BOTH, 1, 0, "both_resp");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'hDEAD_0001, 16'h0, 16'h0, M_NONE, 0, 0, "timeout");
    // Response on the last allowed WAIT cycle is still accepted.
    run_txn(1'b1, 32'h0, 16'h0A0A, 16'h0B0B, M_OK, TMO, 0, "last_cycle");
  endtask

  task automatic test_backpressure();
    run_txn(1'b0, 32'hCAFE_F00D, 16'h0, 16'h0, M_OK, 3, 10, "backpressure");
    run_txn(1'b1, 32'h0, 16'h5555, 16'hAAAA, M_OK, 1, 5, "backpressure2");
  endtask

  task automatic test_stray();
    @(negedge CLK);
    heard_ena = 1'b1; heard_v = 32'h0BAD_0BAD; heard2_ena = 1'b1;
    #1;
    total++;
    if ({heard_rdy, heard2_rdy} !== 2'b00) begin
      bad++; $display("FAIL stray_rdy: got %b required 00", {heard_rdy, heard2_rdy});
    end
    @(negedge CLK);
    heard_ena = 1'b0; heard2_ena = 1'b0;
    @(negedge CLK);
    check_idle_status("stray");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      logic        k;
      logic [31:0] v;
      logic [15:0] a, b;
      k = 1'($urandom_range(0, 1));
      v = $urandom;
      a = 16'($urandom);
      b = 16'($urandom);
      run_txn(k, v, a, b, int'($urandom_range(0, 4)), int'($urandom_range(1, 7)),
              int'($urandom_range(0, 3)), "b2b");
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge CLK);
    cmd_ena = 1'b1; cmd_kind = 1'b0; cmd_v = 32'h7777_7777;
    say_rdy = 1'b1; say2_rdy = 1'b1;
    @(negedge CLK);
    cmd_ena = 1'b0;
    @(negedge CLK);
    total++;
    if (heard_rdy !== 1'b1) begin
      bad++; $display("FAIL rst_wait_entered: got heard_rdy=%b required 1", heard_rdy);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    pass_m = '0; fail_m = '0; tmo_m = '0; lat_m = '0;
    check_idle_status("rst_wait");
    repeat (TMO + 2) @(negedge CLK);
    check_idle_status("rst_wait_quiet");
  endtask

  initial begin
    test_reset();
    test_say();
    test_say2();
    test_wrong();
    test_timeout();
    test_backpressure();
    test_stray();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
